// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// derived sizes and the per-byte source selector used by the merge logic.
package reg_file_mp_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_NUM_RD     = 2;

  // Where a merged byte comes from.
  typedef enum logic [1:0] {
    SRC_STORED = 2'd0,
    SRC_PORT0  = 2'd1,
    SRC_PORT1  = 2'd2
  } byte_src_e;

  function automatic int unsigned strb_width(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned rf_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rf_byte_merge.sv
// Per-byte priority merge of a stored word with two write ports.
// Port 1 wins over port 0 where both hit and strobe the same byte.
module rf_byte_merge
  import reg_file_mp_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] i_base,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [STRB_WIDTH-1:0] i_strb0,
  input  logic                  i_hit0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [STRB_WIDTH-1:0] i_strb1,
  input  logic                  i_hit1,
  output logic [DATA_WIDTH-1:0] o_merged
);

  // Select each byte from port 1, port 0 or the stored word, in that priority.
  always_comb begin
    byte_src_e w_src;
    w_src    = SRC_STORED;
    o_merged = i_base;
    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
      w_src = SRC_STORED;
      if (i_hit0 && i_strb0[b]) w_src = SRC_PORT0;
      if (i_hit1 && i_strb1[b]) w_src = SRC_PORT1;
      case (w_src)
        SRC_PORT0: o_merged[b*8 +: 8] = i_data0[b*8 +: 8];
        SRC_PORT1: o_merged[b*8 +: 8] = i_data1[b*8 +: 8];
        default:   o_merged[b*8 +: 8] = i_base[b*8 +: 8];
      endcase
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two byte-strobed
// write ports, optional write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int unsigned NUM_RD     = DEF_NUM_RD,
  parameter  bit          BYPASS     = 1'b1,
  parameter  bit          ZERO_REG   = 1'b1,
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH),
  localparam int unsigned DEPTH      = rf_depth(ADDR_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic [STRB_WIDTH-1:0]        wstrb0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [STRB_WIDTH-1:0]        wstrb1,
  input  logic                         busy_set,
  input  logic [ADDR_WIDTH-1:0]        busy_addr
);

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  logic                  w_wr0;
  logic                  w_wr1;
  logic                  w_same_waddr;
  logic [DATA_WIDTH-1:0] w_commit0;
  logic [DATA_WIDTH-1:0] w_commit1;
  logic [DEPTH-1:0]      w_busy_set;
  logic [DEPTH-1:0]      w_busy_clr;

  // Effective data writes: dropped while in reset and, with ZERO_REG, at address 0.
  // Gating on rst also keeps the bypass path from showing write data during reset.
  assign w_wr0        = wen0 && !rst && !(ZERO_REG && (waddr0 == '0));
  assign w_wr1        = wen1 && !rst && !(ZERO_REG && (waddr1 == '0));
  assign w_same_waddr = (waddr0 == waddr1);

  // Each write port commits the fully merged word for its address, so on a
  // collision both ports write the identical priority-resolved value.
  rf_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_wmerge0 (
    .i_base   (r_rf[waddr0]),
    .i_data0  (wdata0),
    .i_strb0  (wstrb0),
    .i_hit0   (w_wr0),
    .i_data1  (wdata1),
    .i_strb1  (wstrb1),
    .i_hit1   (w_wr1 && w_same_waddr),
    .o_merged (w_commit0)
  );

  rf_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_wmerge1 (
    .i_base   (r_rf[waddr1]),
    .i_data0  (wdata0),
    .i_strb0  (wstrb0),
    .i_hit0   (w_wr0 && w_same_waddr),
    .i_data1  (wdata1),
    .i_strb1  (wstrb1),
    .i_hit1   (w_wr1),
    .o_merged (w_commit1)
  );

  // Register array: clear on reset, commit merged words on enabled writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (w_wr0) r_rf[waddr0] <= w_commit0;
      if (w_wr1) r_rf[waddr1] <= w_commit1;
    end
  end

  // Scoreboard set/clear vectors; clears ignore strobes, set ignores address 0 with ZERO_REG.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (busy_set && !(ZERO_REG && (busy_addr == '0))) w_busy_set[busy_addr] = 1'b1;
    if (wen0) w_busy_clr[waddr0] = 1'b1;
    if (wen1) w_busy_clr[waddr1] = 1'b1;
  end

  // Busy scoreboard: set takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_set | (r_busy & ~w_busy_clr);
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_zero;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_wr_hit;
    logic                  w_set_hit;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_raddr   = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_zero    = ZERO_REG && (w_raddr == '0);
    assign w_hit0    = BYPASS && w_wr0 && (waddr0 == w_raddr);
    assign w_hit1    = BYPASS && w_wr1 && (waddr1 == w_raddr);
    assign w_wr_hit  = BYPASS && ((wen0 && (waddr0 == w_raddr)) || (wen1 && (waddr1 == w_raddr)));
    assign w_set_hit = busy_set && (busy_addr == w_raddr);

    rf_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_rmerge (
      .i_base   (r_rf[w_raddr]),
      .i_data0  (wdata0),
      .i_strb0  (wstrb0),
      .i_hit0   (w_hit0),
      .i_data1  (wdata1),
      .i_strb1  (wstrb1),
      .i_hit1   (w_hit1),
      .o_merged (w_merged)
    );

    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = w_zero ? '0 : w_merged;
    assign rbusy[g] = !w_zero && r_busy[w_raddr] && !(w_wr_hit && !w_set_hit);
  end

endmodule
